// File: rtl/nios_system_switch_irq_ctrl.sv
// Switch PIO for the Nios II: 2-flop sync, per-bit debounce, edge capture, maskable level irq.
// Latency: in_port change at edge k -> DATA at edge k+1+DEBOUNCE_CYCLES -> readdata one edge later.
// Backpressure: none; the slave accepts every access, readdata is registered every clock.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   address, chipselect,  Avalon-MM slave: 0 DATA (RO), 1 EDGE_CFG (rise [W-1:0], fall [W+15:16]),
//   write_n, writedata    2 IRQ_MASK, 3 CAPTURE (write-1-to-clear)
//   in_port               raw asynchronous switch inputs
//   readdata              registered read data (address sampled every clock, no side effects)
//   irq                   registered level interrupt = |(capture & mask)
//
// Optional feature macro: SWITCH_DEBOUNCE_EN. When defined, each bit must differ from the
// debounced value for DEBOUNCE_CYCLES consecutive clocks before it is accepted. When undefined,
// the debounced value simply follows the synchronizer output and DEBOUNCE_CYCLES is ignored.

module nios_system_switch_irq_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Elaboration-time parameter range checks.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be in 1..32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end

  // The fall-enable field starts at bit 16 of a 32-bit word, so only the low 16 switches
  // can have a fall enable; wider configurations leave upper fall enables at 0.
  localparam int FALL_W = (WIDTH > 16) ? 16 : WIDTH;

  logic [WIDTH-1:0]  sync1_q, sync2_q;
  logic [WIDTH-1:0]  deb_q, deb_d;
  logic [WIDTH-1:0]  rise_en_q, rise_en_d;
  logic [FALL_W-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  cap_q, cap_d;
  logic              irq_q, irq_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              wr_en;
  logic [WIDTH-1:0]  fall_en_full;
  logic [WIDTH-1:0]  edge_set;
  logic              wr_unused;

  assign wr_en        = chipselect & ~write_n;
  assign fall_en_full = WIDTH'(fall_en_q);
  // Not every writedata bit maps to a register field.
  assign wr_unused    = &{1'b0, writedata};

`ifdef SWITCH_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // A bit is accepted only after it has disagreed with the debounced value on
  // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    deb_d = sync2_q;
  end
`endif

  // Edges are detected on the debounced value at the moment it changes.
  assign edge_set = (deb_d & ~deb_q & rise_en_q) | (~deb_d & deb_q & fall_en_full);

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask_d    = mask_q;
    cap_d     = cap_q;
    if (wr_en) begin
      case (address)
        2'd1: begin
          rise_en_d = writedata[WIDTH-1:0];
          fall_en_d = writedata[16 +: FALL_W];
        end
        2'd2:    mask_d = writedata[WIDTH-1:0];
        2'd3:    cap_d  = cap_q & ~writedata[WIDTH-1:0];
        default: ;
      endcase
    end
    // Applied after the clear so a new edge wins over a same-cycle write-1-to-clear.
    cap_d = cap_d | edge_set;

    irq_d = |(cap_q & mask_q);

    readdata_d = '0;
    case (address)
      2'd0: readdata_d[WIDTH-1:0] = deb_q;
      2'd1: begin
        readdata_d[WIDTH-1:0]  = rise_en_q;
        readdata_d[16 +: FALL_W] = readdata_d[16 +: FALL_W] | fall_en_q;
      end
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      default: readdata_d[WIDTH-1:0] = cap_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      rise_en_q  <= '1;
      fall_en_q  <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_system_switch_irq_ctrl.sv
// Self-checking bench for nios_system_switch_irq_ctrl (WIDTH=8, DEBOUNCE_CYCLES=4).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// Reference model: a switch bit is accepted once the last N synchronized samples all disagree with it.

module tb_nios_system_switch_irq_ctrl;

  localparam int W  = 8;
  localparam int DB = 4;
`ifdef SWITCH_DEBOUNCE_EN
  localparam int DBE = DB;
`else
  localparam int DBE = 1;
`endif
  // Falling edges after the change until readdata (address 0) shows the new value.
  localparam int DATA_LAT = DBE + 3;
  localparam int SETTLE   = DBE + 4;

  logic        clk;
  logic        reset_n   = 1'b0;
  logic [1:0]  address   = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n   = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [W-1:0] in_port  = '0;
  logic [31:0] readdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  nios_system_switch_irq_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // hist[0] is the in_port sample taken at the previous edge, hist[j] the one j edges before that.
  // The synchronized value seen at an edge is the sample from two edges earlier (hist[1]).
  logic [W-1:0] hist [0:DBE];
  logic [W-1:0] m_deb  = '0;
  logic [W-1:0] m_rise = '1;
  logic [W-1:0] m_fall = '0;
  logic [W-1:0] m_mask = '0;
  logic [W-1:0] m_cap  = '0;
  logic         m_irq  = 1'b0;
  logic [31:0]  m_rd   = '0;

  function automatic logic [W-1:0] win_deb();
    logic [W-1:0] nd;
    logic         diff;
    nd = m_deb;
    for (int b = 0; b < W; b++) begin
      diff = 1'b1;
      for (int j = 1; j <= DBE; j++) begin
        if (hist[j][b] == m_deb[b]) diff = 1'b0;
      end
      if (diff) nd[b] = ~m_deb[b];
    end
    return nd;
  endfunction

  function automatic logic [W-1:0] edges_of(input logic [W-1:0] od, input logic [W-1:0] nd);
    return (~od & nd & m_rise) | (od & ~nd & m_fall);
  endfunction

  function automatic logic [31:0] rd_of(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_deb};
      2'd1:    return {8'h0, m_fall, 8'h0, m_rise};
      2'd2:    return {24'h0, m_mask};
      default: return {24'h0, m_cap};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= DBE; j++) hist[j] <= '0;
      m_deb  <= '0;
      m_rise <= '1;
      m_fall <= '0;
      m_mask <= '0;
      m_cap  <= '0;
      m_irq  <= 1'b0;
      m_rd   <= '0;
    end else begin
      hist[0] <= in_port;
      for (int j = 1; j <= DBE; j++) hist[j] <= hist[j-1];
      m_deb <= win_deb();
      m_irq <= |(m_cap & m_mask);
      m_rd  <= rd_of(address);
      if (chipselect && !write_n && address == 2'd1) begin
        m_rise <= writedata[7:0];
        m_fall <= writedata[23:16];
      end
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[7:0];
      m_cap <= ((chipselect && !write_n && address == 2'd3) ? (m_cap & ~writedata[7:0]) : m_cap)
               | edges_of(m_deb, win_deb());
    end
  end

  // ---------------- bus helpers (called right after a falling edge) ----------------
  task automatic do_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_rd(input logic [1:0] a, output logic [31:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    v = readdata;
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    do_wr(2'd2, 32'h0000_00FF);
    do_wr(2'd1, 32'h00FF_00FF);
    in_port = 8'h3C;
    idle(SETTLE);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL reset_pre_irq: got %b expected 1", irq); end
    in_port = 8'h10;
    idle(2);
    reset_n = 1'b0;
    #1;
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 00000000", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    idle(2);
    reset_n = 1'b1;
    do_rd(2'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_capture: got %h expected 00000000", v); end
    do_rd(2'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h expected 00000000", v); end
    do_rd(2'd1, v);
    checks++; if (v !== 32'h0000_00FF) begin errors++; $display("FAIL reset_edge_cfg: got %h expected 000000ff", v); end
    idle(SETTLE);
    do_rd(2'd0, v);
    checks++; if (v !== 32'h10) begin errors++; $display("FAIL reset_held_data: got %h expected 00000010", v); end
    do_rd(2'd3, v);
    checks++; if (v !== 32'h10) begin errors++; $display("FAIL reset_held_capture: got %h expected 00000010", v); end
    in_port = 8'h00;
    idle(SETTLE);
    do_wr(2'd3, 32'hFF);
  endtask

  task automatic test_debounce();
    logic [31:0] v;
    int first;
    first = -1;
    in_port = 8'h05;
    address = 2'd0; chipselect = 1'b1; write_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      checks++;
      if (readdata !== m_rd) begin errors++; $display("FAIL debounce_trace[%0d]: got %h expected %h", n, readdata, m_rd); end
      if (first < 0 && readdata[7:0] == 8'h05) first = n;
    end
    chipselect = 1'b0;
    checks++; if (first !== DATA_LAT) begin errors++; $display("FAIL debounce_latency: got %0d expected %0d", first, DATA_LAT); end
    in_port = 8'h85;
    idle(3);
    in_port = 8'h05;
    idle(SETTLE + 2);
    do_rd(2'd0, v);
    checks++; if (v !== 32'h05) begin errors++; $display("FAIL pulse_data: got %h expected 00000005", v); end
    do_rd(2'd3, v);
    checks++;
    if (v !== (32'h05 | ((DBE == 1) ? 32'h80 : 32'h00))) begin
      errors++; $display("FAIL pulse_capture: got %h expected %h", v, 32'h05 | ((DBE == 1) ? 32'h80 : 32'h00));
    end
    do_wr(2'd3, 32'hFF);
  endtask

  task automatic test_edge_cfg();
    logic [31:0] v;
    in_port = 8'h00;
    idle(SETTLE);
    do_wr(2'd3, 32'hFF);
    do_wr(2'd1, 32'h0001_0000);
    do_rd(2'd1, v);
    checks++; if (v !== 32'h0001_0000) begin errors++; $display("FAIL cfg_readback: got %h expected 00010000", v); end
    in_port = 8'h01;
    idle(SETTLE);
    do_rd(2'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL cfg_rise_ignored: got %h expected 00000000", v); end
    in_port = 8'h00;
    idle(SETTLE);
    do_rd(2'd3, v);
    checks++; if (v !== 32'h01) begin errors++; $display("FAIL cfg_fall_captured: got %h expected 00000001", v); end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", irq); end
    do_wr(2'd2, 32'h01);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_same_edge: got %b expected 0", irq); end
    idle(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b expected 1", irq); end
    do_wr(2'd3, 32'h00);
    do_rd(2'd3, v);
    checks++; if (v !== 32'h01) begin errors++; $display("FAIL irq_write0_capture: got %h expected 00000001", v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_write0_irq: got %b expected 1", irq); end
    do_wr(2'd3, 32'h01);
    do_rd(2'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL irq_clear_capture: got %h expected 00000000", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear_irq: got %b expected 0", irq); end
  endtask

  task automatic test_simul_clear();
    logic [31:0] v;
    do_wr(2'd1, 32'h0000_00FF);
    in_port = 8'h04;
    // The write below commits on the same edge the debounced bit 2 rises.
    idle(1 + DBE);
    do_wr(2'd3, 32'h04);
    do_rd(2'd3, v);
    checks++; if (v !== 32'h04) begin errors++; $display("FAIL simul_clear: got %h expected 00000004", v); end
    checks++; if (v !== m_rd) begin errors++; $display("FAIL simul_clear_model: got %h expected %h", v, m_rd); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      checks++;
      if (readdata !== m_rd) begin errors++; $display("FAIL random_readdata[%0d]: got %h expected %h", i, readdata, m_rd); end
      checks++;
      if (irq !== m_irq) begin errors++; $display("FAIL random_irq[%0d]: got %b expected %b", i, irq, m_irq); end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    idle(3);
    reset_n = 1'b1;
    idle(1);
    test_reset();
    test_debounce();
    test_edge_cfg();
    test_irq();
    test_simul_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios_system_switch_irq_ctrl.md
Name: nios_system_switch_irq_ctrl

Overview:
Avalon-MM slave that sits between the DE1-SoC slide switches and the Nios II.
- Synchronizes and debounces each switch bit.
- Detects configurable rising/falling edges into a sticky capture register.
- Raises a maskable level interrupt, so software no longer polls the raw switch PIO.
- Read path keeps the existing PIO timing: readdata registered every clock, 1-cycle latency.

Parameters:
WIDTH, 8, number of switch inputs (1..32).
DEBOUNCE_CYCLES, 50000, consecutive clk cycles a synchronized input must differ from the debounced value before the change is accepted (1 ms at 50 MHz); legal range >= 2.

Ports:
clk  input  1  system clock; all state on rising edge.
reset_n  input  1  asynchronous active-low reset; clears all state.
address  input  2  register select.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0.
writedata  input  32  write data.
in_port  input  WIDTH  raw asynchronous switch inputs.
readdata  output  32  registered read data.
irq  output  1  active-high level interrupt to Nios.

Behaviour:
- Register map (unused upper bits read 0):
  - 0 DATA: debounced value, RO; writes ignored.
  - 1 EDGE_CFG: bits[WIDTH-1:0] rise enable, bits[WIDTH+15:16] fall enable.
  - 2 IRQ_MASK: bits[WIDTH-1:0].
  - 3 CAPTURE: bits[WIDTH-1:0]; write-1-to-clear, writing 0 has no effect.
- Reset values: readdata=0, irq=0, sync flops=0, debounced=0, counters=0, rise enable=all 1, fall enable=0, mask=0, capture=0.
- Synchronizer: 2 flops per bit (sync1, sync2).
- Debounce, per bit, independent counter of width clog2(DEBOUNCE_CYCLES):
  - sync2==debounced: counter <= 0.
  - Differs and counter < DEBOUNCE_CYCLES-1: counter increments.
  - Differs and counter == DEBOUNCE_CYCLES-1: debounced <= sync2, counter <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Latency: in_port change sampled at edge k -> debounced updates at edge k+1+DEBOUNCE_CYCLES -> visible on readdata (address 0) one edge later.
- Edge capture: set on the same edge debounced updates.
  - Rising (0->1) sets the bit if its rise enable=1.
  - Falling (1->0) sets the bit if its fall enable=1.
  - Bits are sticky until cleared.
- Simultaneous CAPTURE write-1-clear and new edge on the same bit in the same cycle: bit remains 1 (edge wins).
- Config/mask writes take effect the next cycle; they do not retroactively set or clear capture bits.
- irq = |(capture & mask), driven from registers (no combinational path from in_port); updates the cycle after capture/mask change.
- readdata <= mux(address) every clock regardless of chipselect; reads have no side effects.
- Reset mid-operation: all state returns to reset values immediately.
  - A switch held high through reset produces a rising edge once debounced (capture set if rise enabled).

Optional Feature:
SWITCH_DEBOUNCE_EN
- Defined: debounce counters as above.
- Undefined: no counters; debounced <= sync2 every cycle, so debounced updates at edge k+2.
  - DEBOUNCE_CYCLES is ignored.
  - Edge capture and irq logic are unchanged.

Test Plan:
(bench uses WIDTH=8, DEBOUNCE_CYCLES=4, SWITCH_DEBOUNCE_EN defined)
- Reset: assert reset_n=0 mid-traffic -> readdata=0, irq=0; read addr1 -> 0x000000FF; addr2, addr3 -> 0.
- Debounce: in_port 0x00->0x05 held 10 cycles -> addr0 reads 0x05; DATA updates exactly 1+4 edges after sampling; 3-cycle pulse 0x80 -> DATA stays 0x05, CAPTURE bit7=0.
- Rise/fall config:
  - Write addr1=0x00010000 (bit0 fall only).
  - Toggle bit0 0->1 -> CAPTURE=0.
  - Toggle bit0 1->0 -> CAPTURE=0x01.
- Interrupt: mask addr2=0x01 with CAPTURE=0x01 -> irq=1 next cycle; write addr3=0x01 -> CAPTURE=0, irq=0; write addr3=0x00 -> no change.
- Simultaneous clear: schedule bit2 debounced rise on the same edge as write addr3=0x04 -> CAPTURE bit2=1 after the edge.
- Macro off: recompile without SWITCH_DEBOUNCE_EN; in_port 0x00->0x03 -> DATA=0x03 two edges after sampling; a 1-cycle glitch is captured.
